mac_accum: RTL and testbench



---
 rtl/mac_accum.sv | 132 +++++++++++++
 tb/tb_mac_accum.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum.sv
// mac_accum: reduces the nine 5-bit products of the 3x3 multiplier array
// through a 3-stage pipelined adder tree and accumulates the window sums
// over a group of beats closed by in_last. On group close, emits one
// saturated sum with its beat count and a sticky saturation flag.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_last   beat qualifier and group-close tag
//   p1..p9              unsigned 5-bit products
//   out_valid           single-cycle result strobe
//   out_data            group sum, clamped to 2^ACC_W-1
//   out_count           beats in group, clamped to 2^CNT_W-1
//   out_sat             group sum clamped at some point in the group
module mac_accum #(
   parameter int unsigned ACC_W = 16,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_last,
   input  logic [4:0]       p1,
   input  logic [4:0]       p2,
   input  logic [4:0]       p3,
   input  logic [4:0]       p4,
   input  logic [4:0]       p5,
   input  logic [4:0]       p6,
   input  logic [4:0]       p7,
   input  logic [4:0]       p8,
   input  logic [4:0]       p9,
   output logic             out_valid,
   output logic [ACC_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat
);

   localparam int unsigned S1_W  = 6;
   localparam int unsigned S2_W  = 7;
   localparam int unsigned WS_W  = 9;
   localparam int unsigned NXT_W = ACC_W + 1;
   localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [S1_W-1:0]  r_s1a, r_s1b, r_s1c, r_s1d, r_s1e;
   logic [S2_W-1:0]  r_s2a, r_s2b, r_s2c;
   logic [WS_W-1:0]  r_wsum;
   logic             r_v1, r_l1, r_v2, r_l2, r_v3, r_l3;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sat;

   logic [NXT_W-1:0] w_nxt;
   logic             w_ovf;
   logic [ACC_W-1:0] w_clamp;
   logic [CNT_W-1:0] w_cnt_inc;

   // Adder tree: data stages update every cycle, tags ride alongside
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1a  <= '0;
         r_s1b  <= '0;
         r_s1c  <= '0;
         r_s1d  <= '0;
         r_s1e  <= '0;
         r_s2a  <= '0;
         r_s2b  <= '0;
         r_s2c  <= '0;
         r_wsum <= '0;
         r_v1   <= 1'b0;
         r_l1   <= 1'b0;
         r_v2   <= 1'b0;
         r_l2   <= 1'b0;
         r_v3   <= 1'b0;
         r_l3   <= 1'b0;
      end else begin
         r_s1a  <= S1_W'(p1) + S1_W'(p2);
         r_s1b  <= S1_W'(p3) + S1_W'(p4);
         r_s1c  <= S1_W'(p5) + S1_W'(p6);
         r_s1d  <= S1_W'(p7) + S1_W'(p8);
         r_s1e  <= S1_W'(p9);
         r_s2a  <= S2_W'(r_s1a) + S2_W'(r_s1b);
         r_s2b  <= S2_W'(r_s1c) + S2_W'(r_s1d);
         r_s2c  <= S2_W'(r_s1e);
         r_wsum <= WS_W'(r_s2a) + WS_W'(r_s2b) + WS_W'(r_s2c);
         r_v1   <= in_valid;
         r_l1   <= in_valid & in_last;
         r_v2   <= r_v1;
         r_l2   <= r_l1;
         r_v3   <= r_v2;
         r_l3   <= r_l2;
      end
   end

   // acc never exceeds ACC_MAX and wsum < 2^ACC_W, so the carry bit alone flags overflow
   always_comb begin
      w_nxt     = NXT_W'(r_acc) + NXT_W'(r_wsum);
      w_ovf     = w_nxt[ACC_W];
      w_clamp   = w_ovf ? ACC_MAX : w_nxt[ACC_W-1:0];
      w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
   end

   // Accumulate stage; output registers hold between pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_sat     <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_sat   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (r_v3) begin
            if (r_l3) begin
               out_valid <= 1'b1;
               out_data  <= w_clamp;
               out_count <= w_cnt_inc;
               out_sat   <= r_sat | w_ovf;
               r_acc     <= '0;
               r_cnt     <= '0;
               r_sat     <= 1'b0;
            end else begin
               r_acc <= w_clamp;
               r_cnt <= w_cnt_inc;
               r_sat <= r_sat | w_ovf;
            end
         end
      end
   end

endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: two instances (16/8 and 9/4 widths) share one input
// stream; a group-level model predicts each result from the group total and
// beat count, clamped to each instance's limits.
module tb_mac_accum;

   localparam int unsigned ACC_A = 16;
   localparam int unsigned CNT_A = 8;
   localparam int unsigned ACC_B = 9;
   localparam int unsigned CNT_B = 4;

   typedef struct {
      int due;
      int total;
      int beats;
   } exp_t;

   logic clk;
   logic rst_n;
   logic in_valid;
   logic in_last;
   logic [4:0] p [9];

   logic             a_valid;
   logic [ACC_A-1:0] a_data;
   logic [CNT_A-1:0] a_count;
   logic             a_sat;
   logic             b_valid;
   logic [ACC_B-1:0] b_data;
   logic [CNT_B-1:0] b_count;
   logic             b_sat;

   exp_t q[$];
   int   cyc;
   int   n_chk;
   int   n_pass;
   int   m_total;
   int   m_beats;
   int   hd [2];
   int   hc [2];
   int   hs [2];

   mac_accum #(.ACC_W(ACC_A), .CNT_W(CNT_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
      .p1(p[0]), .p2(p[1]), .p3(p[2]), .p4(p[3]), .p5(p[4]),
      .p6(p[5]), .p7(p[6]), .p8(p[7]), .p9(p[8]),
      .out_valid(a_valid), .out_data(a_data), .out_count(a_count), .out_sat(a_sat)
   );

   mac_accum #(.ACC_W(ACC_B), .CNT_W(CNT_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
      .p1(p[0]), .p2(p[1]), .p3(p[2]), .p4(p[3]), .p5(p[4]),
      .p6(p[5]), .p7(p[6]), .p8(p[7]), .p9(p[8]),
      .out_valid(b_valid), .out_data(b_data), .out_count(b_count), .out_sat(b_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, obs, exp);
   endtask

   function automatic int window_sum();
      int s = 0;
      for (int i = 0; i < 9; i++) s += int'(p[i]);
      return s;
   endfunction

   task automatic set_all(input int v);
      for (int i = 0; i < 9; i++) p[i] = 5'(v);
   endtask

   task automatic set_rand();
      for (int i = 0; i < 9; i++) p[i] = 5'($urandom_range(0, 31));
   endtask

   // Expected held/pulsed outputs of both instances against the DUTs
   task automatic check_outputs(input bit pulse);
      chk("a_valid", 32'(a_valid), 32'(pulse));
      chk("a_data",  32'(a_data),  32'(hd[0]));
      chk("a_count", 32'(a_count), 32'(hc[0]));
      chk("a_sat",   32'(a_sat),   32'(hs[0]));
      chk("b_valid", 32'(b_valid), 32'(pulse));
      chk("b_data",  32'(b_data),  32'(hd[1]));
      chk("b_count", 32'(b_count), 32'(hc[1]));
      chk("b_sat",   32'(b_sat),   32'(hs[1]));
   endtask

   // One clock with the given tags; model and outputs are checked 1 time unit after the edge
   task automatic step(input logic v, input logic l);
      exp_t e;
      bit   pulse;
      int   amax;
      int   cmax;
      in_valid = v;
      in_last  = l;
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n && v) begin
         m_total += window_sum();
         m_beats++;
         if (l) begin
            e.due   = cyc + 3;
            e.total = m_total;
            e.beats = m_beats;
            q.push_back(e);
            m_total = 0;
            m_beats = 0;
         end
      end
      pulse = (q.size() > 0) && (q[0].due == cyc);
      if (pulse) begin
         e = q.pop_front();
         for (int k = 0; k < 2; k++) begin
            amax  = (k == 0) ? (1 << ACC_A) - 1 : (1 << ACC_B) - 1;
            cmax  = (k == 0) ? (1 << CNT_A) - 1 : (1 << CNT_B) - 1;
            hd[k] = (e.total > amax) ? amax : e.total;
            hs[k] = (e.total > amax) ? 1 : 0;
            hc[k] = (e.beats > cmax) ? cmax : e.beats;
         end
      end
      check_outputs(pulse);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0);
   endtask

   // Assert reset asynchronously, drop everything in flight, hold for n edges
   task automatic do_reset(input int n);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      #1;
      m_total = 0;
      m_beats = 0;
      q.delete();
      for (int k = 0; k < 2; k++) begin
         hd[k] = 0;
         hc[k] = 0;
         hs[k] = 0;
      end
      check_outputs(1'b0);
      idle(n);
      rst_n = 1'b1;
   endtask

   initial begin
      cyc     = 0;
      n_chk   = 0;
      n_pass  = 0;
      set_all(0);
      do_reset(3);

      // Single beat, all p=4 -> 36, count 1
      set_all(4);
      step(1'b1, 1'b1);
      set_all(0);
      idle(5);

      // Three consecutive beats -> 108, count 3
      set_all(4);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      idle(5);

      // Same beats with 2-cycle bubbles (bubble data differs and must be ignored)
      step(1'b1, 1'b0);
      set_all(31);
      idle(2);
      set_all(4);
      step(1'b1, 1'b0);
      set_all(17);
      idle(2);
      set_all(4);
      step(1'b1, 1'b1);
      idle(5);

      // Groups closing every cycle: 36, 279, 0
      set_all(4);
      step(1'b1, 1'b1);
      set_all(31);
      step(1'b1, 1'b1);
      set_all(0);
      step(1'b1, 1'b1);
      idle(5);

      // 2x279 saturates the 9-bit instance; next single p=1 beat is clean
      set_all(31);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      set_all(1);
      step(1'b1, 1'b1);
      idle(5);

      // 20-beat group: narrow instance count clamps at 15
      set_all(31);
      repeat (19) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      idle(5);

      // 260 beats of 279 overflow 16 bits and an 8-bit count
      repeat (259) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      idle(5);

      // Reset mid-group and mid-pipeline, then a fresh single-beat group
      set_all(4);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      do_reset(2);
      step(1'b1, 1'b1);
      set_all(0);
      idle(5);

      // Random traffic with bubbles and variable group length
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) set_all(31);
         else set_rand();
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
      end
      step(1'b1, 1'b1);
      idle(6);

      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
